// File: rtl/rf_serial_loader_pkg.sv
// rtl/rf_serial_loader_pkg.sv - shared types and frame geometry for rf_serial_loader
// Purpose: FSM state enum, command encodings and frame length helper.
// Ports: none (package rf_loader_pkg).
// Configuration: RF_LOADER_PARITY_EN appends one even-parity bit to every frame.
package rf_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

`ifdef RF_LOADER_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Frame layout: cmd | addr | data [| parity]
   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + PARITY_BITS;
   endfunction

   localparam int FRAME_LEN = frame_len(2, 4);

endpackage

// File: rtl/rf_serial_loader_if.sv
// rtl/rf_serial_loader_if.sv - serial input and register-file port bundle
// Purpose: groups the serial stream and register-file write/read-select signals.
// Ports: ser_in/ser_valid (stream into loader), wr_en/wr_addr/wr_data (write port),
//        rd_addr (read select), busy, frame_err, frame_cnt (status).
// Modports: master = stream source / status observer, slave = the loader.
interface rf_serial_loader_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
);
   logic              ser_in;
   logic              ser_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic              busy;
   logic              frame_err;
   logic [3:0]        frame_cnt;

   modport master (
      output ser_in, ser_valid,
      input  wr_en, wr_addr, wr_data, rd_addr, busy, frame_err, frame_cnt
   );

   modport slave (
      input  ser_in, ser_valid,
      output wr_en, wr_addr, wr_data, rd_addr, busy, frame_err, frame_cnt
   );
endinterface

// File: rtl/rf_serial_loader_shift.sv
// rtl/rf_serial_loader_shift.sv - frame shift register and bit counter
// Purpose: collects serial bits MSB first and flags the final bit of a frame.
// Ports: clk, rst (async, active-high); shift_en_i samples bit_i; clear_i restarts
//        the bit count; last_bit_o high while the next sampled bit completes the
//        frame; frame_o is the full frame including the bit currently on bit_i.
module rf_loader_shift
   import rf_loader_pkg::*;
#(
   parameter int LEN = FRAME_LEN
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           shift_en_i,
   input  logic           clear_i,
   input  logic           bit_i,
   output logic           last_bit_o,
   output logic [LEN-1:0] frame_o
);
   localparam int CNT_W = $clog2(LEN + 1);

   logic [LEN-2:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (shift_en_i) begin
         sreg_d = {sreg_q[LEN-3:0], bit_i};
      end
      // Clear wins so the bit that closes a frame leaves the counter at 0.
      if (clear_i) begin
         cnt_d = '0;
      end else if (shift_en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign last_bit_o = (cnt_q == CNT_W'(LEN - 1));
   // The closing bit is taken straight from the input so the frame is
   // decoded on the same edge that samples it.
   assign frame_o    = {sreg_q, bit_i};

endmodule

// File: rtl/rf_serial_loader.sv
// rtl/rf_serial_loader.sv - serial command loader driving a small register file
// Purpose: deserialises cmd|addr|data frames; write frames pulse wr_en once,
//          read frames update rd_addr; tracks frame errors and good-frame count.
// Ports: clk, rst (async, active-high); bus (rf_serial_loader_if.slave):
//        ser_in/ser_valid in, wr_en/wr_addr/wr_data/rd_addr/busy/frame_err/frame_cnt out.
// Configuration: RF_LOADER_PARITY_EN enables the trailing even-parity check.
module rf_serial_loader
   import rf_loader_pkg::*;
#(
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   rf_serial_loader_if.slave   bus
);
   localparam int FL       = frame_len(ADDR_W, DATA_W);
   localparam int GAP_W    = $clog2(TIMEOUT + 1);
   localparam int CMD_POS  = FL - 1;
   localparam int ADDR_MSB = FL - 2;
   localparam int DATA_MSB = FL - 2 - ADDR_W;

   state_e              state_q, state_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                frame_err_q, frame_err_d;
   logic [3:0]          frame_cnt_q, frame_cnt_d;

   logic                shift_en;
   logic                shift_clr;
   logic                last_bit;
   logic [FL-1:0]       frame;
   logic                frame_ok;
   logic                f_cmd;
   logic [ADDR_W-1:0]   f_addr;
   logic [DATA_W-1:0]   f_data;

   rf_loader_shift #(.LEN(FL)) u_shift (
      .clk        (clk),
      .rst        (rst),
      .shift_en_i (shift_en),
      .clear_i    (shift_clr),
      .bit_i      (bus.ser_in),
      .last_bit_o (last_bit),
      .frame_o    (frame)
   );

   assign f_cmd  = frame[CMD_POS];
   assign f_addr = frame[ADDR_MSB -: ADDR_W];
   assign f_data = frame[DATA_MSB -: DATA_W];

`ifdef RF_LOADER_PARITY_EN
   assign frame_ok = ~^frame;
`else
   assign frame_ok = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_addr_d   = rd_addr_q;
      frame_err_d = frame_err_q;
      frame_cnt_d = frame_cnt_q;
      shift_en    = 1'b0;
      shift_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            gap_d = '0;
            if (bus.ser_valid) begin
               shift_en = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.ser_valid) begin
               shift_en = 1'b1;
               gap_d    = '0;
               if (last_bit) begin
                  // Results are registered on the closing edge, so they are
                  // visible during the single COMMIT cycle.
                  shift_clr = 1'b1;
                  state_d   = COMMIT;
                  if (frame_ok) begin
                     if (f_cmd == CMD_WRITE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = f_addr;
                        wr_data_d = f_data;
                     end
                     if (f_cmd == CMD_READ) begin
                        rd_addr_d = f_addr;
                     end
                     frame_err_d = 1'b0;
                     frame_cnt_d = frame_cnt_q + 4'd1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end
            end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
               state_d     = IDLE;
               gap_d       = '0;
               shift_clr   = 1'b1;
               frame_err_d = 1'b1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gap_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_addr_q   <= rd_addr_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.frame_err = frame_err_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule
